// File: rtl/array_update_pkg.sv
// Shared types and helpers for the flow-controlled array-update pipeline.
// Package-level types use the default configuration. Parametrised instances rebuild the same shapes locally.
package array_update_pkg;

  localparam int unsigned ELEM_W_DEF    = 33;
  localparam int unsigned NUM_ELEMS_DEF = 4;
  localparam int unsigned IDX_W_DEF     = 32;

  // Stage-0 payload at the default widths
  typedef struct packed {
    logic [NUM_ELEMS_DEF*ELEM_W_DEF-1:0] arr;
    logic [IDX_W_DEF-1:0]                idx;
    logic [ELEM_W_DEF-1:0]               val;
    logic                                en;
  } p0_payload_t;

  localparam logic [IDX_W_DEF-1:0] OOB_LIMIT_DEF = IDX_W_DEF'(NUM_ELEMS_DEF);

  function automatic int unsigned elem_slice(input int unsigned i, input int unsigned elem_w);
    return i * elem_w;
  endfunction

  // The index compare must be wide enough for both the full index and NUM_ELEMS itself
  function automatic int unsigned cmp_width(input int unsigned idx_w, input int unsigned num_elems);
    int unsigned need;
    need = $clog2(num_elems + 1);
    return (idx_w > need) ? idx_w : need;
  endfunction

endpackage

// File: rtl/array_update_comb.sv
// Combinational single-element array update with out-of-bounds flag.
module array_update_comb
  import array_update_pkg::*;
#(
  parameter int unsigned ELEM_W    = ELEM_W_DEF,
  parameter int unsigned NUM_ELEMS = NUM_ELEMS_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF
) (
  input  logic [NUM_ELEMS*ELEM_W-1:0] arr,
  input  logic [IDX_W-1:0]            idx,
  input  logic [ELEM_W-1:0]           val,
  input  logic                        en,
  output logic [NUM_ELEMS*ELEM_W-1:0] upd_arr_c,
  output logic                        oob_c
);

  localparam int unsigned      CMP_W     = cmp_width(IDX_W, NUM_ELEMS);
  localparam logic [CMP_W-1:0] OOB_LIMIT = CMP_W'(NUM_ELEMS);

  logic [CMP_W-1:0] idx_ext;

  assign idx_ext = CMP_W'(idx);

  // Out-of-range indices match no element, so the array passes through untouched
  always_comb begin
    upd_arr_c = arr;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      if (en && (idx_ext == CMP_W'(i))) begin
        upd_arr_c[elem_slice(i, ELEM_W) +: ELEM_W] = val;
      end
    end
  end

  assign oob_c = en && (idx_ext >= OOB_LIMIT);

endmodule

// File: rtl/array_update_pipe.sv
// Two-stage valid/ready array-update pipeline.
// Stage 0 captures the request, and stage 1 registers the updated array and the oob flag.
module array_update_pipe
  import array_update_pkg::*;
#(
  parameter int unsigned ELEM_W     = ELEM_W_DEF,
  parameter int unsigned NUM_ELEMS  = NUM_ELEMS_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF,
  parameter int unsigned RESET_DATA = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_ELEMS*ELEM_W-1:0] in_arr,
  input  logic [IDX_W-1:0]            in_idx,
  input  logic [ELEM_W-1:0]           in_val,
  input  logic                        in_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_ELEMS*ELEM_W-1:0] out_arr,
  output logic                        out_oob
);

  localparam int unsigned ARR_W = NUM_ELEMS * ELEM_W;

  typedef struct packed {
    logic [ARR_W-1:0]  arr;
    logic [IDX_W-1:0]  idx;
    logic [ELEM_W-1:0] val;
    logic              en;
  } p0_t;

  p0_t              in_pl_c;
  p0_t              p0_q, p0_d;
  logic             p0_valid_q, p0_valid_d;
  logic             p1_valid_q, p1_valid_d;
  logic [ARR_W-1:0] p1_arr_q, p1_arr_d;
  logic             p1_oob_q, p1_oob_d;
  logic [ARR_W-1:0] upd_arr_c;
  logic             oob_c;
  logic             en0_c, en1_c, accept_c, load1_c;

  array_update_comb #(
    .ELEM_W    (ELEM_W),
    .NUM_ELEMS (NUM_ELEMS),
    .IDX_W     (IDX_W)
  ) u_comb (
    .arr       (p0_q.arr),
    .idx       (p0_q.idx),
    .val       (p0_q.val),
    .en        (p0_q.en),
    .upd_arr_c (upd_arr_c),
    .oob_c     (oob_c)
  );

  // Per-stage enables. Bubbles collapse, and stalled stages hold their data.
  always_comb begin
    en1_c       = !p1_valid_q || out_ready;
    en0_c       = !p0_valid_q || en1_c;
    accept_c    = in_valid && en0_c;
    load1_c     = en1_c && p0_valid_q;

    in_pl_c.arr = in_arr;
    in_pl_c.idx = in_idx;
    in_pl_c.val = in_val;
    in_pl_c.en  = in_en;

    p0_valid_d  = accept_c ? 1'b1 : (en1_c ? 1'b0 : p0_valid_q);
    p1_valid_d  = en1_c ? p0_valid_q : p1_valid_q;
    p0_d        = accept_c ? in_pl_c : p0_q;
    p1_arr_d    = load1_c ? upd_arr_c : p1_arr_q;
    p1_oob_d    = load1_c ? oob_c : p1_oob_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
    end else begin
      p0_valid_q <= p0_valid_d;
      p1_valid_q <= p1_valid_d;
    end
  end

  if (RESET_DATA != 0) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p0_q     <= '0;
        p1_arr_q <= '0;
        p1_oob_q <= 1'b0;
      end else begin
        p0_q     <= p0_d;
        p1_arr_q <= p1_arr_d;
        p1_oob_q <= p1_oob_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      p0_q     <= p0_d;
      p1_arr_q <= p1_arr_d;
      p1_oob_q <= p1_oob_d;
    end
  end

  assign in_ready  = en0_c;
  assign out_valid = p1_valid_q;
  assign out_arr   = p1_arr_q;
  assign out_oob   = p1_oob_q;

endmodule

// File: tb/tb_array_update_pipe.sv
// Directed bench for array_update_pipe: default configuration plus an 8x16 instance with data reset.
module tb_array_update_pipe;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid, in_ready, in_en, out_valid, out_ready, out_oob;
  logic [131:0] in_arr, out_arr;
  logic [31:0]  in_idx;
  logic [32:0]  in_val;

  logic         s_in_valid, s_in_ready, s_in_en, s_out_valid, s_out_ready, s_out_oob;
  logic [127:0] s_in_arr, s_out_arr;
  logic [3:0]   s_in_idx;
  logic [7:0]   s_in_val;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rec_en = 1'b0;

  logic [131:0] q_arr[$];
  logic         q_oob[$];
  int           q_cyc[$];

  localparam logic [131:0] A = {33'h3, 33'h2, 33'h1, 33'h0};

  array_update_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_arr    (in_arr),
    .in_idx    (in_idx),
    .in_val    (in_val),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_arr   (out_arr),
    .out_oob   (out_oob)
  );

  array_update_pipe #(
    .ELEM_W     (8),
    .NUM_ELEMS  (16),
    .IDX_W      (4),
    .RESET_DATA (1)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_arr    (s_in_arr),
    .in_idx    (s_in_idx),
    .in_val    (s_in_val),
    .in_en     (s_in_en),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_arr   (s_out_arr),
    .out_oob   (s_out_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record each main-DUT output that will be taken at the next rising edge
  always @(negedge clk) begin
    if (rec_en && rst_n && out_valid && out_ready) begin
      q_arr.push_back(out_arr);
      q_oob.push_back(out_oob);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [131:0] upd(input logic [131:0] a, input int unsigned idx,
                                       input logic [32:0] v, input bit en);
    logic [131:0] r;
    r = a;
    if (en && idx < 4) r[idx*33 +: 33] = v;
    return r;
  endfunction

  task automatic clear_q();
    q_arr.delete();
    q_oob.delete();
    q_cyc.delete();
  endtask

  // Present one request and return after its acceptance edge; called just after a rising edge
  task automatic send(input logic [131:0] a, input logic [31:0] idx, input logic [32:0] v,
                      input logic en);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_arr   = a;
    in_idx   = idx;
    in_val   = v;
    in_en    = en;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 132'(in_ready), 132'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic shot(input string tag, input logic [131:0] a, input logic [31:0] idx,
                      input logic [32:0] v, input logic en,
                      input logic [131:0] exp_arr, input logic exp_oob);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_arr    = a;
    in_idx    = idx;
    in_val    = v;
    in_en     = en;
    @(negedge clk);
    check({tag, "_in_ready"}, 132'(in_ready), 132'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 132'(out_valid), 132'(0));
    @(negedge clk);
    check({tag, "_valid"}, 132'(out_valid), 132'(1));
    check({tag, "_arr"}, out_arr, exp_arr);
    check({tag, "_oob"}, 132'(out_oob), 132'(exp_oob));
    @(posedge clk);
    #1;
  endtask

  task automatic s_shot(input string tag, input logic [127:0] a, input logic [3:0] idx,
                        input logic [7:0] v, input logic en, input logic [127:0] exp_arr);
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_arr    = a;
    s_in_idx    = idx;
    s_in_val    = v;
    s_in_en     = en;
    @(negedge clk);
    check({tag, "_in_ready"}, 132'(s_in_ready), 132'(1));
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 132'(s_out_valid), 132'(1));
    check({tag, "_arr"}, 132'(s_out_arr), 132'(exp_arr));
    check({tag, "_oob"}, 132'(s_out_oob), 132'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [131:0] held;
    int acc;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_arr      = '0;
    in_idx      = '0;
    in_val      = '0;
    in_en       = 1'b0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_in_arr    = '0;
    s_in_idx    = '0;
    s_in_val    = '0;
    s_in_en     = 1'b0;
    s_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 132'(out_valid), 132'(0));
    check("rst_in_ready", 132'(in_ready), 132'(1));
    check("rst_s_out_valid", 132'(s_out_valid), 132'(0));
    check("rst_s_in_ready", 132'(s_in_ready), 132'(1));
    check("rst_s_out_arr", 132'(s_out_arr), 132'(0));
    check("rst_s_out_oob", 132'(s_out_oob), 132'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 132'(out_valid), 132'(0));

    // Single transactions
    shot("upd_idx1", A, 32'd1, 33'h2A, 1'b1, {33'h3, 33'h2, 33'h2A, 33'h0}, 1'b0);
    shot("upd_idx3", A, 32'd3, 33'h1_FFFF_FFFF, 1'b1, {33'h1_FFFF_FFFF, 33'h2, 33'h1, 33'h0}, 1'b0);
    shot("oob_idx4", A, 32'd4, 33'h2A, 1'b1, A, 1'b1);
    shot("oob_max", A, 32'hFFFF_FFFF, 33'h2A, 1'b1, A, 1'b1);
    shot("dis_idx4", A, 32'd4, 33'h2A, 1'b0, A, 1'b0);
    shot("dis_idx1", A, 32'd1, 33'h2A, 1'b0, A, 1'b0);

    // Back-to-back stream
    clear_q();
    rec_en    = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(A, 32'(k), 33'(33'h100 + k), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("stream_cnt", 132'(q_arr.size()), 132'(8));
    for (int k = 0; k < 8 && k < q_arr.size(); k++) begin
      check($sformatf("stream_arr%0d", k), q_arr[k], upd(A, k, 33'(33'h100 + k), 1'b1));
      check($sformatf("stream_oob%0d", k), 132'(q_oob[k]), 132'(k >= 4));
      check($sformatf("stream_cyc%0d", k), 132'(q_cyc[k] - q_cyc[0]), 132'(k));
    end

    // Downstream stall for 5 cycles while streaming
    clear_q();
    out_ready = 1'b0;
    held      = '0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(A, 32'(k), 33'(33'h200 + k), 1'b1);
      end
      begin
        acc = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          if (c == 2) held = out_arr;
          if (c > 2) check($sformatf("stall_hold%0d", c), out_arr, held);
        end
        check("stall_first", held, upd(A, 0, 33'h200, 1'b1));
        check("stall_accepts", 132'(acc), 132'(2));
        check("stall_in_ready", 132'(in_ready), 132'(0));
        check("stall_out_valid", 132'(out_valid), 132'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stall_cnt", 132'(q_arr.size()), 132'(6));
    for (int k = 0; k < 6 && k < q_arr.size(); k++) begin
      check($sformatf("stall_arr%0d", k), q_arr[k], upd(A, k, 33'(33'h200 + k), 1'b1));
      check($sformatf("stall_oob%0d", k), 132'(q_oob[k]), 132'(k >= 4));
    end

    // Reset while both stages hold data
    clear_q();
    out_ready = 1'b0;
    send(A, 32'd1, 33'h55, 1'b1);
    send(A, 32'd2, 33'h66, 1'b1);
    @(negedge clk);
    check("full_out_valid", 132'(out_valid), 132'(1));
    check("full_in_ready", 132'(in_ready), 132'(0));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 132'(out_valid), 132'(0));
    check("rst_async_ready", 132'(in_ready), 132'(1));
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_stale", 132'(q_arr.size()), 132'(0));
    check("rst_idle_valid", 132'(out_valid), 132'(0));
    rec_en = 1'b0;
    @(posedge clk);
    #1;

    // 8-bit x 16 instance
    s_shot("s_top", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'd15, 8'hA5, 1'b1,
           128'hA50E0D0C_0B0A0908_07060504_03020100);
    s_shot("s_bot", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'd0, 8'h5A, 1'b1,
           128'h0F0E0D0C_0B0A0908_07060504_0302015A);
    s_shot("s_dis", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'd15, 8'hA5, 1'b0,
           128'h0F0E0D0C_0B0A0908_07060504_03020100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
